// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for the cycle simulator.
// Drives the simulator's per-cycle enable and reset. Supports run, step-N,
// host halt, breakpoint and cycle-limit stops, and reports why it halted.
module sim_run_ctrl #(
  parameter int MAX_CYCLE_WIDTH = 32,
  parameter int RESET_HOLD      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [MAX_CYCLE_WIDTH-1:0] cmd_arg,
  output logic                       cmd_err,
  output logic                       sim_en,
  output logic                       sim_rst_n,
  input  logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
  output logic                       running,
  output logic                       evt_valid,
  output logic [1:0]                 halt_cause
);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_RESET_SIM = 3'd1;
  localparam logic [2:0] OP_RUN       = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_HALT      = 3'd4;
  localparam logic [2:0] OP_SET_BP    = 3'd5;
  localparam logic [2:0] OP_CLR_BP    = 3'd6;
  localparam logic [2:0] OP_SET_LIMIT = 3'd7;

  localparam logic [1:0] CAUSE_HOST  = 2'd0;
  localparam logic [1:0] CAUSE_BP    = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [MAX_CYCLE_WIDTH-1:0] CNT_ONE = MAX_CYCLE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RESETTING = 2'd0,
    ST_HALTED    = 2'd1,
    ST_RUN       = 2'd2,
    ST_STEP      = 2'd3
  } state_t;

  state_t                     state_r, state_next_s;
  logic [HOLD_W-1:0]          hold_r;
  logic [MAX_CYCLE_WIDTH-1:0] bp_r, limit_r, step_cnt_r;
  logic                       bp_en_r;
  logic                       cmd_ready_r, running_r, sim_rst_n_r;
  logic                       evt_valid_r, cmd_err_r;
  logic [1:0]                 halt_cause_r;

  logic active_s, fire_s;
  logic bp_hit_s, lim_hit_s, step_done_s, host_halt_s, stop_s;
  logic evt_s, cmd_err_s;
  logic [1:0] cause_s;

  // Stop conditions are combinational on current_cycle so the simulator never overshoots.
  always_comb begin
    active_s    = (state_r == ST_RUN) || (state_r == ST_STEP);
    fire_s      = cmd_valid && cmd_ready_r;
    bp_hit_s    = active_s && bp_en_r && (current_cycle == bp_r);
    lim_hit_s   = active_s && (limit_r != '0) && (current_cycle >= limit_r);
    step_done_s = (state_r == ST_STEP) && (step_cnt_r == '0);
    host_halt_s = active_s && fire_s && (cmd_op == OP_HALT);
    stop_s      = bp_hit_s || lim_hit_s || step_done_s || host_halt_s;
  end

  // State register plus the status outputs that follow the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_RESETTING;
      cmd_ready_r <= 1'b0;
      running_r   <= 1'b0;
      sim_rst_n_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s != ST_RESETTING);
      running_r   <= (state_next_s == ST_RUN) || (state_next_s == ST_STEP);
      sim_rst_n_r <= (state_next_s != ST_RESETTING);
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RESETTING: begin
        if (hold_r <= HOLD_ONE) state_next_s = ST_HALTED;
        else                    state_next_s = ST_RESETTING;
      end
      ST_HALTED: begin
        if (fire_s && (cmd_op == OP_RESET_SIM)) state_next_s = ST_RESETTING;
        else if (fire_s && (cmd_op == OP_RUN))  state_next_s = ST_RUN;
        else if (fire_s && (cmd_op == OP_STEP)) state_next_s = ST_STEP;
        else                                    state_next_s = ST_HALTED;
      end
      ST_RUN, ST_STEP: begin
        if (stop_s) state_next_s = ST_HALTED;
        else        state_next_s = state_r;
      end
      default: state_next_s = ST_RESETTING;
    endcase
  end

  // Output decode: enable, halt cause by priority, illegal-command detect.
  always_comb begin
    sim_en    = active_s && !stop_s;
    evt_s     = active_s && stop_s;
    cmd_err_s = active_s && fire_s &&
                ((cmd_op == OP_RUN) || (cmd_op == OP_STEP) || (cmd_op == OP_RESET_SIM));
    if (bp_hit_s)         cause_s = CAUSE_BP;
    else if (lim_hit_s)   cause_s = CAUSE_LIMIT;
    else if (step_done_s) cause_s = CAUSE_STEP;
    else                  cause_s = CAUSE_HOST;
  end

  // Datapath registers: hold timer, step counter, bp/limit, event reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_r       <= HOLD_INIT;
      step_cnt_r   <= '0;
      bp_r         <= '0;
      bp_en_r      <= 1'b0;
      limit_r      <= '0;
      halt_cause_r <= CAUSE_HOST;
      evt_valid_r  <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      if (state_r == ST_RESETTING && hold_r != '0) hold_r <= hold_r - HOLD_ONE;
      else if (state_next_s == ST_RESETTING)       hold_r <= HOLD_INIT;
      else                                          hold_r <= hold_r;

      if (state_r == ST_HALTED && fire_s && cmd_op == OP_STEP) step_cnt_r <= cmd_arg;
      else if (state_r == ST_STEP && sim_en)                   step_cnt_r <= step_cnt_r - CNT_ONE;
      else                                                      step_cnt_r <= step_cnt_r;

      if (fire_s && cmd_op == OP_SET_BP) begin
        bp_r    <= cmd_arg;
        bp_en_r <= 1'b1;
      end else if (fire_s && cmd_op == OP_CLR_BP) begin
        bp_r    <= bp_r;
        bp_en_r <= 1'b0;
      end else begin
        bp_r    <= bp_r;
        bp_en_r <= bp_en_r;
      end

      if (fire_s && cmd_op == OP_SET_LIMIT) limit_r <= cmd_arg;
      else                                  limit_r <= limit_r;

      // Leaving a simulator reset clears the previous cause silently.
      if (evt_s)                                                      halt_cause_r <= cause_s;
      else if (state_r == ST_RESETTING && state_next_s == ST_HALTED)  halt_cause_r <= CAUSE_HOST;
      else                                                            halt_cause_r <= halt_cause_r;

      evt_valid_r <= evt_s;
      cmd_err_r   <= cmd_err_s;
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign running    = running_r;
  assign sim_rst_n  = sim_rst_n_r;
  assign evt_valid  = evt_valid_r;
  assign cmd_err    = cmd_err_r;
  assign halt_cause = halt_cause_r;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: a simple cycle-counter model stands in for the
// simulator; stop scenarios come from a vector table and a scoreboard queue.
module tb_sim_run_ctrl;

  localparam logic [2:0] OP_NOP = 3'd0, OP_RESET_SIM = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4, OP_SET_BP = 3'd5, OP_CLR_BP = 3'd6, OP_SET_LIMIT = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cmd_err, sim_en, sim_rst_n, running, evt_valid;
  logic [1:0]  halt_cause;
  logic [31:0] cyc = 32'd0;
  logic        preset_req = 1'b0;
  logic [31:0] preset_val = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        bp_en;
    logic [31:0] bp;
    logic [31:0] limit;
    logic [31:0] start;
    logic [2:0]  op;
    logic [31:0] arg;
    logic [31:0] exp_cycle;
    logic [1:0]  exp_cause;
    int          exp_count;
  } vec_t;

  typedef struct {
    logic [31:0] cycle;
    logic [1:0]  cause;
    int          count;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];

  sim_run_ctrl #(.MAX_CYCLE_WIDTH(32), .RESET_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_err(cmd_err), .sim_en(sim_en),
    .sim_rst_n(sim_rst_n), .current_cycle(cyc), .running(running),
    .evt_valid(evt_valid), .halt_cause(halt_cause)
  );

  always #10 clk = ~clk;

  // Stand-in simulator: cycle counter with reset and a bench preset hook.
  always @(posedge clk) begin
    if (!sim_rst_n)      cyc <= 32'd0;
    else if (preset_req) cyc <= preset_val;
    else if (sim_en)     cyc <= cyc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // All tasks below start and end at #1 after a rising edge.
  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 32'd0;
  endtask

  task automatic preset(input logic [31:0] v);
    preset_req = 1'b1; preset_val = v;
    @(posedge clk); #1;
    preset_req = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    check(name, ok, 32'd1);
    @(posedge clk); #1;
  endtask

  // Waits for the halt event, counting enabled cycles, then scores against the queue head.
  task automatic wait_evt(input string name);
    int cnt = 0;
    int seen = 0;
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (evt_valid) begin seen = 1; break; end
      if (sim_en) cnt++;
    end
    check({name, " evt seen"}, seen, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (seen != 0) begin
        check({name, " cycle"}, cyc, e.cycle);
        check({name, " cause"}, {30'd0, halt_cause}, {30'd0, e.cause});
        check({name, " en count"}, cnt, e.count);
        check({name, " running"}, {31'd0, running}, 32'd0);
        @(negedge clk);
        check({name, " evt one pulse"}, {31'd0, evt_valid}, 32'd0);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int low;
    exp_t e;

    //              bp_en bp           limit    start         op       arg    exp_cyc exp_cause cnt
    vecs[0] = '{1'b0, 32'd0,    32'd0,   32'd0,         OP_STEP, 32'd10, 32'd10,  2'd3, 10};
    vecs[1] = '{1'b1, 32'd25,   32'd0,   32'd0,         OP_RUN,  32'd0,  32'd25,  2'd1, 25};
    vecs[2] = '{1'b1, 32'd25,   32'd0,   32'd25,        OP_RUN,  32'd0,  32'd25,  2'd1, 0};
    vecs[3] = '{1'b1, 32'd100,  32'd100, 32'd50,        OP_RUN,  32'd0,  32'd100, 2'd1, 50};
    vecs[4] = '{1'b0, 32'd0,    32'd120, 32'd100,       OP_RUN,  32'd0,  32'd120, 2'd2, 20};
    vecs[5] = '{1'b0, 32'd0,    32'd0,   32'd7,         OP_STEP, 32'd0,  32'd7,   2'd3, 0};
    vecs[6] = '{1'b0, 32'd0,    32'd5,   32'd10,        OP_RUN,  32'd0,  32'd10,  2'd2, 0};
    vecs[7] = '{1'b1, 32'd3,    32'd0,   32'd0,         OP_STEP, 32'd5,  32'd3,   2'd1, 3};
    vecs[8] = '{1'b0, 32'd0,    32'd4,   32'd0,         OP_STEP, 32'd4,  32'd4,   2'd2, 4};
    vecs[9] = '{1'b1, 32'd2,    32'd0,   32'hFFFF_FFFE, OP_RUN,  32'd0,  32'd2,   2'd1, 4};

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check("rst sim_en", {31'd0, sim_en}, 32'd0);
    check("rst sim_rst_n", {31'd0, sim_rst_n}, 32'd0);
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rst evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst halt_cause", {30'd0, halt_cause}, 32'd0);
    check("rst running", {31'd0, running}, 32'd0);

    // Release: simulator reset must stay low exactly RESET_HOLD cycles.
    rst_n = 1'b1;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sim_rst_n) break;
      low++;
    end
    check("hold length", low, 32'd4);
    check("hold cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("hold no evt", {31'd0, evt_valid}, 32'd0);
    @(posedge clk); #1;

    // Table-driven stop scenarios.
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].bp_en) send_cmd(OP_SET_BP, vecs[v].bp);
      else               send_cmd(OP_CLR_BP, 32'd0);
      send_cmd(OP_SET_LIMIT, vecs[v].limit);
      preset(vecs[v].start);
      e.cycle = vecs[v].exp_cycle;
      e.cause = vecs[v].exp_cause;
      e.count = vecs[v].exp_count;
      sb_q.push_back(e);
      send_cmd(vecs[v].op, vecs[v].arg);
      wait_evt($sformatf("vec%0d", v));
    end

    // RESET_SIM from HALTED: cause cleared, simulator cycle back to 0, no event.
    send_cmd(OP_RESET_SIM, 32'd0);
    check("rsim cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rsim sim_rst_n", {31'd0, sim_rst_n}, 32'd0);
    wait_ready("rsim ready");
    check("rsim cause", {30'd0, halt_cause}, 32'd0);
    check("rsim cycle", cyc, 32'd0);
    check("rsim no evt", {31'd0, evt_valid}, 32'd0);

    // Free run, illegal RUN while running, host HALT after 37 clocks.
    send_cmd(OP_CLR_BP, 32'd0);
    send_cmd(OP_SET_LIMIT, 32'd0);
    send_cmd(OP_SET_LIMIT, 32'd0);
    send_cmd(OP_RUN, 32'd0);
    for (int i = 0; i < 37; i++) begin
      if (i == 10) begin cmd_valid = 1'b1; cmd_op = OP_RUN; end
      @(posedge clk); #1;
      if (i == 10) begin
        cmd_valid = 1'b0; cmd_op = OP_NOP;
        check("err pulse", {31'd0, cmd_err}, 32'd1);
        check("err running", {31'd0, running}, 32'd1);
      end
      if (i == 11) check("err one pulse", {31'd0, cmd_err}, 32'd0);
    end
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    check("halt fire sim_en", {31'd0, sim_en}, 32'd0);
    e.cycle = 32'd37; e.cause = 2'd0; e.count = 0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    wait_evt("host halt");

    // rst_n mid-STEP: everything back to reset values, bp/limit forgotten.
    send_cmd(OP_SET_BP, 32'd5000);
    send_cmd(OP_SET_LIMIT, 32'd9000);
    preset(32'd0);
    send_cmd(OP_STEP, 32'd1000);
    repeat (300) @(posedge clk);
    #1;
    check("midstep cycle", cyc, 32'd300);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst sim_en", {31'd0, sim_en}, 32'd0);
    check("midrst sim_rst_n", {31'd0, sim_rst_n}, 32'd0);
    check("midrst running", {31'd0, running}, 32'd0);
    check("midrst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b1;
    wait_ready("midrst ready");
    preset(32'd4995);
    send_cmd(OP_RUN, 32'd0);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (evt_valid) low++;
    end
    check("cleared bp/limit no stop", low, 32'd0);
    e.cycle = 32'd5015; e.cause = 2'd0; e.count = 0;
    sb_q.push_back(e);
    send_cmd(OP_HALT, 32'd0);
    wait_evt("post reset halt");

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
